day: RTL and testbench
======================

Name: day

Overview:
- Streaming calibration-value extractor: consumes one ASCII character per clock from a text line.
- Tracks the first and last decimal digit of the line and presents them as a two-character ASCII result.
- Per-line state is cleared by pulsing reset between lines; the surrounding system converts the result to an integer and accumulates it.
- PART selects plain-digit detection (1) or digits plus spelled-out words (2).

Parameters:
- PART, default 1. 1 = only characters '0'..'9' count as digits. 2 = additionally the lowercase words "one".."nine" count as 1..9.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Clears all per-line state.
- input_char  input  8  ASCII character, sampled every rising edge while rst is high.
- is_num_out  output  1  registered; high in the cycle after a sampled character completed a digit.
- result_out  output  16  [15:8] = ASCII first digit, [7:0] = ASCII last digit; 0x0000 until a digit is seen.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - result_out=0x0000, is_num_out=0, first_valid=0.
  - Character history window cleared to 0x00.
  - Reset asserted mid-line discards all progress; the next line starts clean.
- Every rising edge with rst=1, one character is accepted. No handshake or valid signal exists: every edge is a character.
- Character history: a 4-entry shift register holds the previous 4 accepted chars. With the current char, this forms a 5-char window ending at the current char.
- Digit detection on the accepted char yields digit d (ASCII '1'..'9' or '0'..'9') plus a hit flag:
  - input_char in 0x30..0x39 gives hit, d=input_char.
  - PART=2 only: hit if the window's trailing chars equal one of "one","two","three","four","five","six","seven","eight","nine". d = ASCII of that value, e.g. "nine" gives 0x39.
  - Matching is exact lowercase; any other byte is a non-hit.
  - Overlapping words are detected independently because the window is never cleared on a match. Example: "twone" gives a hit 2 at 'o' and a hit 1 at 'e'.
  - At most one word can end at a given char; no priority logic is needed.
- On a hit:
  - If first_valid=0: result_out[15:8]<=d and first_valid<=1.
  - Always: result_out[7:0]<=d.
  - The first hit of a line therefore sets both bytes (a single-digit line gives "77" style output).
- On a non-hit: result_out holds. is_num_out<=hit every cycle.
- Latency: result_out reflects a character one edge after it is sampled. The result is final one cycle after the last char of the line.
- Extra cycles after the line with input_char held at its last value:
  - Re-sampling a repeated digit rewrites the same last digit, so the result is unchanged.
  - In PART=2, a repeated letter must not create a spurious word and must not clear the result.
- No end-of-line marker; a line ends when rst is asserted.
- result_out is ASCII, not binary. A line with no digits leaves 0x0000, which the consumer converts to 0.

Test Plan:
- PART=1, "1abc2" then 1 idle cycle -> result_out=0x3132, is_num_out pulses after '1' and after '2'.
- PART=1, "treb7uchet" -> 0x3737; "pqr3stu8vwx" -> 0x3338; "abcdef" -> 0x0000.
- PART=2:
  - "two1nine" -> 0x3239.
  - "eightwothree" -> 0x3833.
  - "xtwone3four" -> 0x3234.
  - "7pqrstsixteen" -> 0x3736.
  - "oneight" -> 0x3138, because overlap is kept.
- PART=2, "zoneight234" with last char '4' held 3 extra cycles -> stays 0x3134; "three" with 'e' held 2 extra cycles -> stays 0x3333.
- Reset mid-line: feed "5ab", assert rst low between clock edges -> result_out immediately 0x0000. Release and feed "9" -> 0x3939, not retaining 5.
- PART=1 with the words "one" and "two" present in "one2two" -> 0x3232, since words are ignored.

Source files
------------

// File: rtl/day.sv
// Streaming calibration extractor: tracks first/last digit of a text line.
// PART=2 also recognises the spelled-out words "one".."nine".
module day #(
  parameter int PART = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  input_char,
  output logic        is_num_out,
  output logic [15:0] result_out
);

  logic [31:0] hist;
  logic [39:0] win;
  logic        first_valid;
  logic        is_digit;
  logic        hit;
  logic [7:0]  dig;
  logic [3:0]  wv;

  // hist[7:0] is the previous char; win ends at the current char
  assign win = {hist, input_char};
  assign is_digit = (input_char >= 8'h30) && (input_char <= 8'h39);

  always_comb begin
    wv = 4'd0;
    if (PART == 2) begin
      unique case (1'b1)
        win[23:0] == "one":   wv = 4'd1;
        win[23:0] == "two":   wv = 4'd2;
        win[39:0] == "three": wv = 4'd3;
        win[31:0] == "four":  wv = 4'd4;
        win[31:0] == "five":  wv = 4'd5;
        win[23:0] == "six":   wv = 4'd6;
        win[39:0] == "seven": wv = 4'd7;
        win[39:0] == "eight": wv = 4'd8;
        win[31:0] == "nine":  wv = 4'd9;
        default:              wv = 4'd0;
      endcase
    end
  end

  always_comb begin
    hit = 1'b0;
    dig = 8'h00;
    if (is_digit) begin
      hit = 1'b1;
      dig = input_char;
    end else if (wv != 4'd0) begin
      hit = 1'b1;
      dig = {4'h3, wv};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist        <= 32'h0;
      first_valid <= 1'b0;
      is_num_out  <= 1'b0;
      result_out  <= 16'h0;
    end else begin
      hist       <= {hist[23:0], input_char};
      is_num_out <= hit;
      if (hit) begin
        result_out[7:0] <= dig;
        if (!first_valid) begin
          result_out[15:8] <= dig;
          first_valid      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_day.sv
// Directed bench for day: PART=1 and PART=2 instances share one stimulus
// stream; expected results are hand-computed per line.
module tb_day;

  logic        clk;
  logic        rst;
  logic [7:0]  input_char;
  logic        n1, n2;
  logic [15:0] r1, r2;

  int n_tests = 0;
  int n_fail  = 0;

  day #(.PART(1)) u1 (
    .clk(clk), .rst(rst), .input_char(input_char),
    .is_num_out(n1), .result_out(r1)
  );

  day #(.PART(2)) u2 (
    .clk(clk), .rst(rst), .input_char(input_char),
    .is_num_out(n2), .result_out(r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic new_line(input string tag);
    @(negedge clk);
    #1 rst = 1'b0;
    input_char = 8'h00;
    #1;
    chk({tag, "_rst1"}, {n1, r1}, 17'h0);
    chk({tag, "_rst2"}, {n2, r2}, 17'h0);
    #1 rst = 1'b1;
  endtask

  task automatic step(input logic [7:0] c);
    input_char = c;
    @(negedge clk);
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i]);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic line(input string s, input logic [15:0] e1,
                      input logic [15:0] e2);
    new_line(s);
    feed(s);
    chk({s, "_p1"}, r1, e1);
    chk({s, "_p2"}, r2, e2);
  endtask

  initial begin
    rst = 1'b0;
    input_char = 8'h00;
    hold(2);
    chk("init_r1", r1, 16'h0);
    chk("init_n1", {15'h0, n1}, 16'h0);

    new_line("pulse");
    step("1");
    chk("pulse_n_1", {15'h0, n1}, 16'h1);
    step("a");
    chk("pulse_n_a", {15'h0, n1}, 16'h0);
    step("b");
    step("c");
    chk("pulse_n_c", {15'h0, n1}, 16'h0);
    step("2");
    chk("pulse_n_2", {15'h0, n1}, 16'h1);
    hold(1);
    chk("pulse_r", r1, 16'h3132);

    line("treb7uchet",  16'h3737, 16'h3737);
    line("pqr3stu8vwx", 16'h3338, 16'h3338);
    line("abcdef",      16'h0000, 16'h0000);

    line("two1nine",      16'h3131, 16'h3239);
    line("eightwothree",  16'h0000, 16'h3833);
    line("xtwone3four",   16'h3333, 16'h3234);
    line("7pqrstsixteen", 16'h3737, 16'h3736);
    line("oneight",       16'h0000, 16'h3138);
    line("one2two",       16'h3232, 16'h3132);

    new_line("twone");
    step("t");
    step("w");
    step("o");
    chk("twone_n_o", {15'h0, n2}, 16'h1);
    step("n");
    chk("twone_n_n", {15'h0, n2}, 16'h0);
    step("e");
    chk("twone_n_e", {15'h0, n2}, 16'h1);
    chk("twone_r", r2, 16'h3231);

    line("zoneight234", 16'h3234, 16'h3134);
    hold(3);
    chk("zon_hold_p2", r2, 16'h3134);
    chk("zon_hold_p1", r1, 16'h3234);

    line("three", 16'h0000, 16'h3333);
    hold(2);
    chk("three_hold", r2, 16'h3333);
    chk("three_hold_n", {15'h0, n2}, 16'h0);

    new_line("mid");
    feed("5ab");
    chk("mid_pre", r2, 16'h3535);
    #1 rst = 1'b0;
    #1;
    chk("mid_async1", r1, 16'h0);
    chk("mid_async2", r2, 16'h0);
    #1 rst = 1'b1;
    step("9");
    chk("mid_post1", r1, 16'h3939);
    chk("mid_post2", r2, 16'h3939);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
